// File: rtl/fifo_test_sequencer.sv
// -----------------------------------------------------------------------------
// fifo_test_sequencer
//
// Runs a FIFO under test through a fixed sequence of phases and checks the data
// it returns:
//   RST_PH  : holds the FIFO in reset for two cycles
//   FILL    : writes an ascending count until the FIFO is full or DEPTH entries
//             have been written
//   DRAIN   : reads until the FIFO reports empty, then waits one cycle so the
//             last read can be checked
//   RAND    : issues LFSR-driven random writes and reads for RAND_CYCLES cycles
//   MID_RST : makes sure the FIFO holds data, then resets it mid-traffic
//   CHK_RST : confirms that the reset emptied the FIFO
//   DONE    : holds the result until the next start
//
// Write data is the running write count. Read data is compared against the
// running read count, so both sequences wrap at 2^DATA_WIDTH.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   start        one-cycle pulse, starts a run from IDLE or DONE
//   fifo_full    FIFO full flag
//   fifo_empty   FIFO empty flag
//   fifo_rdata   FIFO read data, valid the cycle after an accepted read
//   fifo_rst     synchronous active-high reset to the FIFO
//   fifo_wr_en   write strobe, already gated by fifo_full
//   fifo_wdata   write data (low bits of the write count)
//   fifo_rd_en   read strobe, already gated by fifo_empty
//   phase        current state encoding (IDLE=0 ... DONE=7)
//   busy         high while a run is in progress
//   done         high in DONE
//   pass         valid while done=1; high when no error was counted
//   err_cnt      saturating error count
// -----------------------------------------------------------------------------
module fifo_test_sequencer #(
  parameter int          DATA_WIDTH  = 4,
  parameter int          DEPTH       = 8,
  parameter int          RAND_CYCLES = 32,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rst,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  fifo_rd_en,
  output logic [2:0]            phase,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_cnt
);

  localparam int CYC_W = $clog2(RAND_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_PH  = 3'd1,
    FILL    = 3'd2,
    DRAIN   = 3'd3,
    RAND    = 3'd4,
    MID_RST = 3'd5,
    CHK_RST = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t state, state_next;

  // One-bit sub-step shared by RST_PH (reset cycle 1/2), DRAIN (drain/settle)
  // and MID_RST (reset cycle 1/2). It is cleared on every state exit.
  logic step, step_next;

  logic [15:0]           wr_cnt;
  logic [15:0]           rd_cnt;
  logic [CYC_W-1:0]      cyc_cnt;
  logic [15:0]           lfsr;
  logic                  chk;
  logic [DATA_WIDTH-1:0] exp_data;

  // Request and control strobes produced by the FSM decode.
  logic wr_req;
  logic rd_req;
  logic run_clr;
  logic fill_err;
  logic rst_err;
  logic resync;
  logic rand_step;

  logic       mismatch;
  logic [1:0] err_inc;
  logic [8:0] err_sum;
  logic [7:0] err_next;
  logic       lfsr_fb;

  // Fibonacci LFSR, taps 16,14,13,11 (bit 16 is the MSB).
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Zero-cycle gating: a strobe never reaches the FIFO while the flag that
  // forbids it is set, whatever the FSM requests.
  assign fifo_wr_en = wr_req & ~fifo_full;
  assign fifo_rd_en = rd_req & ~fifo_empty;
  assign fifo_wdata = wr_cnt[DATA_WIDTH-1:0];

  assign phase = state;
  assign busy  = (state != IDLE) && (state != DONE);
  assign done  = (state == DONE);
  assign pass  = (state == DONE) && (err_cnt == 8'd0);

  // Up to three error sources can fire in the same cycle; the count saturates.
  assign mismatch = chk && (fifo_rdata != exp_data);
  assign err_inc  = {1'b0, mismatch} + {1'b0, fill_err} + {1'b0, rst_err};
  assign err_sum  = {1'b0, err_cnt} + {7'd0, err_inc};
  assign err_next = err_sum[8] ? 8'hFF : err_sum[7:0];

  // ---------------------------------------------------------------------------
  // Next-state and request decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned and no latch is inferred.
    state_next = state;
    step_next  = step;
    wr_req     = 1'b0;
    rd_req     = 1'b0;
    fifo_rst   = 1'b0;
    run_clr    = 1'b0;
    fill_err   = 1'b0;
    rst_err    = 1'b0;
    resync     = 1'b0;
    rand_step  = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          run_clr    = 1'b1;
          step_next  = 1'b0;
          state_next = RST_PH;
        end
      end

      RST_PH: begin
        fifo_rst  = 1'b1;
        step_next = 1'b1;
        if (step) begin
          step_next  = 1'b0;
          state_next = FILL;
        end
      end

      FILL: begin
        wr_req = (wr_cnt != 16'(DEPTH));
        if (fifo_full || (wr_cnt == 16'(DEPTH))) begin
          // A full flag before DEPTH writes means the FIFO is smaller than
          // advertised; the state exits here so this is counted once.
          fill_err   = fifo_full && (wr_cnt < 16'(DEPTH));
          step_next  = 1'b0;
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        if (!step) begin
          rd_req = 1'b1;
          if (fifo_empty) begin
            step_next = 1'b1;
          end
        end else begin
          // Settle cycle: the last read's data is checked here.
          step_next  = 1'b0;
          state_next = RAND;
        end
      end

      RAND: begin
        wr_req    = lfsr[0];
        rd_req    = lfsr[1];
        rand_step = 1'b1;
        if (cyc_cnt == CYC_W'(RAND_CYCLES - 1)) begin
          step_next  = 1'b0;
          state_next = MID_RST;
        end
      end

      MID_RST: begin
        if (!step && fifo_empty) begin
          // The reset only proves something if the FIFO held data, so force
          // one write first.
          wr_req = 1'b1;
        end else begin
          fifo_rst  = 1'b1;
          step_next = 1'b1;
          if (step) begin
            step_next  = 1'b0;
            state_next = CHK_RST;
          end
        end
      end

      CHK_RST: begin
        rst_err    = !fifo_empty;
        resync     = 1'b1;
        state_next = DONE;
      end

      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters, LFSR and read-check pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (rst) begin
      state    <= IDLE;
      step     <= 1'b0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      err_cnt  <= '0;
      cyc_cnt  <= '0;
      lfsr     <= LFSR_SEED;
      chk      <= 1'b0;
      exp_data <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;

      if (run_clr) begin
        wr_cnt  <= '0;
        rd_cnt  <= '0;
        err_cnt <= '0;
        cyc_cnt <= '0;
        lfsr    <= LFSR_SEED;
        chk     <= 1'b0;
      end else begin
        if (fifo_wr_en) begin
          wr_cnt <= wr_cnt + 16'd1;
        end

        // After the mid-traffic reset the FIFO is empty, so the next read
        // should return the next value to be written.
        if (resync) begin
          rd_cnt <= wr_cnt;
        end else if (fifo_rd_en) begin
          rd_cnt <= rd_cnt + 16'd1;
        end

        if (rand_step) begin
          lfsr    <= {lfsr[14:0], lfsr_fb};
          cyc_cnt <= cyc_cnt + 1'b1;
        end

        err_cnt <= err_next;

        // Read data arrives one cycle after the strobe; no check is armed
        // while the FIFO is being reset.
        chk <= fifo_rd_en && !fifo_rst;
      end

      if (fifo_rd_en) begin
        exp_data <= rd_cnt[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: doc/fifo_test_sequencer.md
# fifo_test_sequencer

Synthesizable controller that sequences the FIFO under test through four fixed phases: reset, ordered fill/drain, LFSR-driven random read/write, and a mid-traffic reset. It drives the FIFO's reset, write and read ports and self-checks read data against a running expected counter. It reports phase, pass/fail and an error count to the testbench top level. It replaces the free-running handshake flags the bench currently uses to sequence these phases.

## Interface
- DATA_WIDTH, 4, FIFO data width.
- DEPTH, 8, FIFO depth in entries; must be ≥ 2.
- RAND_CYCLES, 32, number of cycles spent in the random phase; must be ≥ 1.
- LFSR_SEED, 16'hACE1, non-zero seed for the 16-bit Fibonacci LFSR (taps 16,14,13,11).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE, ignored otherwise.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read.
- fifo_rst  out  1  reset to the FIFO (synchronous, active-high).
- fifo_wr_en  out  1  write strobe, = wr_req & ~fifo_full (combinational gate).
- fifo_wdata  out  DATA_WIDTH  = wr_cnt[DATA_WIDTH-1:0].
- fifo_rd_en  out  1  read strobe, = rd_req & ~fifo_empty (combinational gate).
- phase  out  3  current state encoding (below).
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- pass  out  1  valid when done=1; 1 iff err_cnt == 0.
- err_cnt  out  8  saturating mismatch count.

## Operation
- States and encoding: IDLE=0, RST_PH=1, FILL=2, DRAIN=3, RAND=4, MID_RST=5, CHK_RST=6, DONE=7.
- IDLE: all strobes 0. On start, clear wr_cnt, rd_cnt, err_cnt and cyc_cnt, load LFSR_SEED into the LFSR, and go to RST_PH.
- RST_PH: fifo_rst=1 for exactly 2 cycles, then go to FILL.
- FILL: wr_req=1. Leave when fifo_full=1 is seen or wr_cnt == DEPTH, then go to DRAIN. If the FIFO reports full before DEPTH writes, increment err_cnt once.
- DRAIN: rd_req=1 until fifo_empty=1, then wait 1 cycle for the final data check and go to RAND.
- RAND: wr_req=lfsr[0] and rd_req=lfsr[1]. The LFSR advances every cycle. cyc_cnt counts to RAND_CYCLES, then go to MID_RST.
- MID_RST: entry requires the FIFO non-empty. While fifo_empty=1, force one write (wr_req=1, rd_req=0). Once non-empty, assert fifo_rst for 2 cycles and go to CHK_RST.
- CHK_RST: 1 cycle. If fifo_empty=0, increment err_cnt. Reset rd_cnt := wr_cnt so the expected sequence resynchronizes. Go to DONE.
- DONE: hold outputs; done=1. start returns to RST_PH with counters cleared.
- Accepted write = fifo_wr_en, which increments wr_cnt.
- Accepted read = fifo_rd_en. It registers exp = rd_cnt[DATA_WIDTH-1:0] and a check flag, then increments rd_cnt.
- One cycle after the check flag, if fifo_rdata != exp, increment err_cnt.
- wr_cnt and rd_cnt are 16 bits; comparisons use the low DATA_WIDTH bits, so wrap at 2^DATA_WIDTH is expected.
- Simultaneous accepted read and write in one cycle: both counters update and both actions are legal.
- err_cnt saturates at 255.
- Check flags are suppressed in any cycle where fifo_rst=1.

## Timing
- Reset values: all strobes 0; fifo_rst=0; phase=IDLE; busy=0; done=0; pass=0; err_cnt=0; LFSR=LFSR_SEED.
- State, counters and the LFSR are registered. fifo_wr_en and fifo_rd_en are combinational from state and the full/empty flags, so there is zero-cycle gating against full/empty.
- Read-check latency: rd_en at cycle t, compare at t+1.
- rst mid-run: the next cycle is IDLE, all strobes drop, and the pending check is discarded.
- start while busy is ignored.
- pass is meaningful only while done=1. It is computed from the final err_cnt, including any CHK_RST increment.

## Test plan
- Behavioural FIFO (DEPTH=8, DATA_WIDTH=4) plus a start pulse -> phases 1,2,3,4,5,6,7 in order; 8 writes of data 0..7; 8 reads returning 0..7; done=1, pass=1, err_cnt=0.
- FIFO model corrupts the 3rd read (returns 4'hF instead of 2) -> err_cnt=1 at done, pass=0.
- FIFO model asserts full after 6 writes -> FILL exits after 6 writes, err_cnt ≥ 1, pass=0.
- RAND phase with RAND_CYCLES=32 and the seed default -> fifo_wr_en never high with fifo_full=1, fifo_rd_en never high with fifo_empty=1; data wraps past 4'hF and still checks clean (err_cnt=0).
- FIFO model ignores fifo_rst (stays non-empty) -> err_cnt incremented in CHK_RST, pass=0.
- rst asserted for 1 cycle during DRAIN -> next cycle phase=IDLE, strobes 0, err_cnt=0. A subsequent start completes a clean run with pass=1.
